// File: rtl/int_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: register offsets, FSM encoding
// and the request codes driven onto the core's 8-bit interrupt flag bus.
package int_arbiter_pkg;

  localparam logic [7:0] INT_ARB_ENABLE  = 8'h00;
  localparam logic [7:0] INT_ARB_PENDING = 8'h04;
  localparam logic [7:0] INT_ARB_EDGE    = 8'h08;
  localparam logic [7:0] INT_ARB_CLAIM   = 8'h0C;

  localparam logic [7:0] INT_REQ  = 8'h01;
  localparam logic [7:0] INT_NONE = 8'h00;

  typedef enum logic [2:0] {
    S_ARB_IDLE    = 3'b001,
    S_ARB_REQ     = 3'b010,
    S_ARB_SERVICE = 3'b100
  } arb_state_t;

endpackage

// File: rtl/int_arb_sync.sv
// Two-flop synchroniser per interrupt line plus a rising-edge detect on the
// synchronised value.
module int_arb_sync
  import int_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [NUM_SRC-1:0] src_q,
  output logic [NUM_SRC-1:0] src_rise
);

  logic [NUM_SRC-1:0] sync_p0;
  logic [NUM_SRC-1:0] sync_p1;
  logic [NUM_SRC-1:0] sync_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= src_i;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign src_q    = sync_p1;
  assign src_rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/int_arbiter.sv
// Interrupt front end: pending/enable/edge registers, winner selection and a
// REQ/SERVICE tracker. Define INT_ARB_RR_EN for round-robin arbitration.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic [7:0]         int_flag_o,
  output logic [ID_W-1:0]    int_id_o,
  input  logic               ack_i,
  input  logic               complete_i
);

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_rise;

  int_arb_sync #(.NUM_SRC(NUM_SRC)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .src_i    (src_i),
    .src_q    (src_q),
    .src_rise (src_rise)
  );

  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] id_mask;
  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    search_start;
  logic [31:0]        rdata;
  logic               ack_take;
  logic               load_id;
  arb_state_t         state_q;
  arb_state_t         state_d;

  // Lowest set bit of req, searching upward from start and wrapping.
  function automatic logic [ID_W-1:0] pick(input logic [NUM_SRC-1:0] req,
                                           input logic [ID_W-1:0]    start);
    logic [2*NUM_SRC-1:0] sh;
    logic                 found;
    logic [ID_W-1:0]      id;
    int                   w;
    sh    = {req, req} >> start;
    found = 1'b0;
    id    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && sh[i]) begin
        found = 1'b1;
        w     = int'(start) + i;
        if (w >= NUM_SRC) w = w - NUM_SRC;
        id    = w[ID_W-1:0];
      end
    end
    return id;
  endfunction

  assign wdata    = NUM_SRC'(data_i);
  assign cand     = pending_q & enable_q;
  assign id_mask  = NUM_SRC'(1) << id_q;
  assign ack_take = (state_q == S_ARB_REQ) && ack_i;
  assign w1c      = (we_i && addr_i == INT_ARB_PENDING) ? wdata : '0;
  assign ack_clr  = ack_take ? id_mask : '0;

  // Edge bits: a new rising edge beats any same-cycle clear.
  assign pending_d = (edge_q & ((pending_q & ~(w1c | ack_clr)) | src_rise))
                   | (~edge_q & src_q);

`ifdef INT_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (ack_take) begin
      rr_ptr <= (id_q == ID_W'(NUM_SRC - 1)) ? '0 : id_q + 1'b1;
    end
  end

  assign search_start = rr_ptr;
`else
  assign search_start = '0;
`endif

  assign win_id = pick(cand, search_start);

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
    end else begin
      if (we_i && addr_i == INT_ARB_ENABLE) enable_q <= wdata;
      if (we_i && addr_i == INT_ARB_EDGE)   edge_q   <= wdata;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_id = 1'b0;
    case (state_q)
      S_ARB_IDLE: begin
        if (cand != '0) begin
          state_d = S_ARB_REQ;
          load_id = 1'b1;
        end
      end
      S_ARB_REQ: begin
        if (ack_i)                        state_d = S_ARB_SERVICE;
        else if ((cand & id_mask) == '0)  state_d = S_ARB_IDLE;
      end
      S_ARB_SERVICE: begin
        if (complete_i) state_d = S_ARB_IDLE;
      end
      default: state_d = S_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ARB_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_id) id_q <= win_id;
    end
  end

  assign int_flag_o = (state_q == S_ARB_REQ) ? INT_REQ : INT_NONE;
  assign int_id_o   = id_q;

  always_comb begin
    rdata = '0;
    case (addr_i)
      INT_ARB_ENABLE:  rdata = 32'(enable_q);
      INT_ARB_PENDING: rdata = 32'(pending_q);
      INT_ARB_EDGE:    rdata = 32'(edge_q);
      INT_ARB_CLAIM:   rdata = {(state_q != S_ARB_IDLE), {(31-ID_W){1'b0}}, id_q};
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) data_o <= '0;
    else     data_o <= rdata;
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: edge/level sources, priority, withdrawal,
// W1C collision and reset during service.
module tb_int_arbiter;
  import int_arbiter_pkg::*;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 5;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] src_i;
  logic               we_i;
  logic [7:0]         addr_i;
  logic [31:0]        data_i;
  logic [31:0]        data_o;
  logic [7:0]         int_flag_o;
  logic [ID_W-1:0]    int_id_o;
  logic               ack_i;
  logic               complete_i;

  int tests = 0;
  int fails = 0;
  logic [31:0] rv;

  int_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_i      (src_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .int_flag_o (int_flag_o),
    .int_id_o   (int_id_o),
    .ack_i      (ack_i),
    .complete_i (complete_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; data_i = d;
    step(1);
    we_i = 1'b0; data_i = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    addr_i = a;
    step(1);
    d = data_o;
  endtask

  task automatic pulse_ack();
    ack_i = 1'b1; step(1); ack_i = 1'b0;
  endtask

  task automatic pulse_complete();
    complete_i = 1'b1; step(1); complete_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src_i = '0; we_i = 1'b0; addr_i = '0; data_i = '0;
    ack_i = 1'b0; complete_i = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset state
    check("rst_flag", 32'(int_flag_o), 32'h0);
    check("rst_id", 32'(int_id_o), 32'h0);
    check("rst_data", data_o, 32'h0);
    rd(INT_ARB_ENABLE, rv);  check("rst_enable", rv, 32'h0);
    rd(INT_ARB_PENDING, rv); check("rst_pending", rv, 32'h0);
    rd(INT_ARB_CLAIM, rv);   check("rst_claim", rv, 32'h0);

    // Single edge source 0, 4-edge latency
    wr(INT_ARB_ENABLE, 32'h01);
    wr(INT_ARB_EDGE, 32'h01);
    rd(INT_ARB_EDGE, rv);    check("edge_rb", rv, 32'h01);
    src_i = 8'h01;
    step(3);
    check("e0_flag_early", 32'(int_flag_o), 32'h00);
    step(1);
    check("e0_flag", 32'(int_flag_o), 32'h01);
    check("e0_id", 32'(int_id_o), 32'h0);
    src_i = 8'h00;
    pulse_ack();
    check("e0_flag_svc", 32'(int_flag_o), 32'h00);
    rd(INT_ARB_PENDING, rv); check("e0_pend_ack", rv, 32'h0);
    rd(INT_ARB_CLAIM, rv);   check("e0_claim_svc", rv, 32'h8000_0000);
    pulse_complete();
    rd(INT_ARB_CLAIM, rv);   check("e0_claim_done", rv, 32'h0);

    // Fixed priority: sources 5 and 2 together
    wr(INT_ARB_ENABLE, 32'h24);
    wr(INT_ARB_EDGE, 32'h24);
    src_i = 8'h24;
    step(4);
    check("pri_flag", 32'(int_flag_o), 32'h01);
    check("pri_id_first", 32'(int_id_o), 32'd2);
    src_i = 8'h00;
    pulse_ack();
    check("pri_svc_flag", 32'(int_flag_o), 32'h00);
    check("pri_svc_id", 32'(int_id_o), 32'd2);
    pulse_complete();
    check("pri_idle_flag", 32'(int_flag_o), 32'h00);
    step(1);
    check("pri_flag2", 32'(int_flag_o), 32'h01);
    check("pri_id_second", 32'(int_id_o), 32'd5);
    pulse_ack();
    pulse_complete();
    rd(INT_ARB_PENDING, rv); check("pri_pend_clear", rv, 32'h0);

    // Level source 3 withdrawn before ack
    wr(INT_ARB_EDGE, 32'h00);
    wr(INT_ARB_ENABLE, 32'h08);
    src_i = 8'h08;
    step(4);
    check("lvl_flag", 32'(int_flag_o), 32'h01);
    check("lvl_id", 32'(int_id_o), 32'd3);
    src_i = 8'h00;
    step(4);
    check("lvl_withdraw_flag", 32'(int_flag_o), 32'h00);
    rd(INT_ARB_CLAIM, rv);   check("lvl_claim", rv, 32'h0000_0003);
    rd(INT_ARB_PENDING, rv); check("lvl_pend", rv, 32'h0);

    // Disabled edge source 1 stays pending, then enabled
    wr(INT_ARB_ENABLE, 32'h00);
    wr(INT_ARB_EDGE, 32'h02);
    src_i = 8'h02;
    step(1);
    src_i = 8'h00;
    step(4);
    check("dis_flag", 32'(int_flag_o), 32'h00);
    rd(INT_ARB_PENDING, rv); check("dis_pend", rv, 32'h02);
    wr(INT_ARB_ENABLE, 32'h02);
    step(1);
    check("dis_en_flag", 32'(int_flag_o), 32'h01);
    check("dis_en_id", 32'(int_id_o), 32'd1);
    pulse_ack();
    pulse_complete();
    complete_i = 1'b1; step(1); complete_i = 1'b0;
    ack_i = 1'b1; step(1); ack_i = 1'b0;
    rd(INT_ARB_CLAIM, rv);   check("stray_ack_claim", rv, 32'h0000_0001);

    // W1C on the same cycle as a new edge on source 4
    wr(INT_ARB_ENABLE, 32'h00);
    wr(INT_ARB_EDGE, 32'h10);
    src_i = 8'h10;
    step(2);
    wr(INT_ARB_PENDING, 32'h10);
    rd(INT_ARB_PENDING, rv); check("w1c_collide", rv, 32'h10);
    wr(INT_ARB_PENDING, 32'h10);
    rd(INT_ARB_PENDING, rv); check("w1c_plain", rv, 32'h0);
    src_i = 8'h00;
    wr(32'h10, 32'hFF);
    rd(8'h10, rv);           check("unmapped_rd", rv, 32'h0);
    rd(INT_ARB_ENABLE, rv);  check("unmapped_wr", rv, 32'h0);

    // Reset while in SERVICE
    wr(INT_ARB_EDGE, 32'h01);
    wr(INT_ARB_ENABLE, 32'h01);
    src_i = 8'h01;
    step(4);
    check("rs_flag", 32'(int_flag_o), 32'h01);
    src_i = 8'h00;
    pulse_ack();
    rst = 1'b1; step(1); rst = 1'b0;
    check("rs_flag_after", 32'(int_flag_o), 32'h00);
    check("rs_id_after", 32'(int_id_o), 32'h0);
    rd(INT_ARB_ENABLE, rv);  check("rs_enable", rv, 32'h0);
    rd(INT_ARB_PENDING, rv); check("rs_pending", rv, 32'h0);
    rd(INT_ARB_CLAIM, rv);   check("rs_claim", rv, 32'h0);
    pulse_complete();
    rd(INT_ARB_CLAIM, rv);   check("rs_late_complete", rv, 32'h0);
    check("rs_late_flag", 32'(int_flag_o), 32'h00);

`ifdef INT_ARB_RR_EN
    // Round-robin between two held level sources
    wr(INT_ARB_EDGE, 32'h00);
    wr(INT_ARB_ENABLE, 32'h03);
    src_i = 8'h03;
    step(4);
    check("rr_id0", 32'(int_id_o), 32'd0);
    pulse_ack();
    pulse_complete();
    step(1);
    check("rr_flag1", 32'(int_flag_o), 32'h01);
    check("rr_id1", 32'(int_id_o), 32'd1);
    pulse_ack();
    pulse_complete();
    step(1);
    check("rr_id2", 32'(int_id_o), 32'd0);
    src_i = 8'h00;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
